sram_like_arbiter: RTL and testbench

Shares one SRAM-like memory bus between the instruction-fetch requester and the M-stage data requester. The data requester carries the byte strobes and replicated write data already produced by the M-stage memory control logic. The block arbitrates between the two requesters and sequences each transaction through the bus address and data handshakes. It returns read data with a one-cycle completion pulse that the pipeline hazard logic uses to release its stall. It handles pipeline flush while a transaction is in flight.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/sram_like_arb_grant.sv | 38 +++
 rtl/sram_like_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SRAM-like bus arbiter.
//   state_e : arbiter sequencing states
//   owner_e : which requester owns the current transaction
//   SIZE_*  : bus transfer size encodings
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/sram_like_arb_grant.sv
// Combinational requester picker.
//   inst_req_i / data_req_i : qualified requests
//   ptr_i                   : round-robin pointer (favoured owner on conflict)
//   gnt_valid_o             : some request is pending
//   gnt_owner_o             : selected owner
// Build option: ARB_RR_EN selects round-robin on conflict; otherwise data
// always beats inst.
module sram_like_arb_grant
  import mem_arb_pkg::*;
(
  input  logic   inst_req_i,
  input  logic   data_req_i,
  input  owner_e ptr_i,
  output logic   gnt_valid_o,
  output owner_e gnt_owner_o
);

`ifdef ARB_RR_EN
  always_comb begin
    gnt_valid_o = inst_req_i | data_req_i;
    gnt_owner_o = DATA;
    if (inst_req_i && data_req_i) begin
      gnt_owner_o = ptr_i;
    end else if (inst_req_i) begin
      gnt_owner_o = INST;
    end
  end
`else
  logic unused_ptr;
  assign unused_ptr = ptr_i;

  always_comb begin
    gnt_valid_o = inst_req_i | data_req_i;
    gnt_owner_o = data_req_i ? DATA : INST;
  end
`endif

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and M-stage data access.
// One transaction outstanding; result returned with a one-cycle ok pulse.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   flush                    : cancels delivery of the in-flight result
//   inst_req/addr/rdata/ok   : fetch requester
//   data_req/wr/size/addr/wstrb/wdata/rdata/ok : data requester
//   bus_req/wr/size/addr/wstrb/wdata          : bus request (registered)
//   bus_addr_ok/data_ok/rdata                 : bus responses
//   busy                     : transaction in progress
// Build option: ARB_RR_EN (round-robin arbitration on conflict).
module sram_like_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            inst_req,
  input  logic [AW-1:0]   inst_addr,
  output logic [DW-1:0]   inst_rdata,
  output logic            inst_ok,
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [1:0]      data_size,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW/8-1:0] data_wstrb,
  input  logic [DW-1:0]   data_wdata,
  output logic [DW-1:0]   data_rdata,
  output logic            data_ok,
  output logic            bus_req,
  output logic            bus_wr,
  output logic [1:0]      bus_size,
  output logic [AW-1:0]   bus_addr,
  output logic [DW/8-1:0] bus_wstrb,
  output logic [DW-1:0]   bus_wdata,
  input  logic            bus_addr_ok,
  input  logic            bus_data_ok,
  input  logic [DW-1:0]   bus_rdata,
  output logic            busy
);

  localparam int SW = DW / 8;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d;
  owner_e          ptr_q, ptr_d;
  logic            cancel_q, cancel_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_wr_q, bus_wr_d;
  logic [1:0]      bus_size_q, bus_size_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [SW-1:0]   bus_wstrb_q, bus_wstrb_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
  logic            inst_ok_q, inst_ok_d;
  logic            data_ok_q, data_ok_d;
  logic [DW-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DW-1:0]   data_rdata_q, data_rdata_d;

  logic            gnt_valid;
  owner_e          gnt_owner;

  // A requester still high during its own ok cycle is already finished.
  sram_like_arb_grant u_grant (
    .inst_req_i  (inst_req & ~inst_ok_q),
    .data_req_i  (data_req & ~data_ok_q),
    .ptr_i       (ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_owner_o (gnt_owner)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    cancel_d     = cancel_q;
    bus_req_d    = bus_req_q;
    bus_wr_d     = bus_wr_q;
    bus_size_d   = bus_size_q;
    bus_addr_d   = bus_addr_q;
    bus_wstrb_d  = bus_wstrb_q;
    bus_wdata_d  = bus_wdata_q;
    inst_ok_d    = 1'b0;
    data_ok_d    = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid && !flush) begin
          state_d   = REQ;
          owner_d   = gnt_owner;
          ptr_d     = (gnt_owner == DATA) ? INST : DATA;
          cancel_d  = 1'b0;
          bus_req_d = 1'b1;
          if (gnt_owner == DATA) begin
            bus_wr_d    = data_wr;
            bus_size_d  = data_size;
            bus_addr_d  = data_addr;
            bus_wstrb_d = data_wr ? data_wstrb : '0;
            bus_wdata_d = data_wdata;
          end else begin
            bus_wr_d    = 1'b0;
            bus_size_d  = SIZE_W;
            bus_addr_d  = inst_addr;
            bus_wstrb_d = '0;
            bus_wdata_d = '0;
          end
        end
      end
      REQ: begin
        // The request cannot be withdrawn once raised; a flush only
        // marks the result for discard.
        if (bus_addr_ok) begin
          bus_req_d = 1'b0;
          state_d   = (flush || cancel_q) ? DRAIN : WAIT;
        end else if (flush) begin
          cancel_d = 1'b1;
        end
      end
      WAIT: begin
        if (bus_data_ok) begin
          state_d = IDLE;
          if (!flush) begin
            if (owner_q == DATA) begin
              data_rdata_d = bus_rdata;
              data_ok_d    = 1'b1;
            end else begin
              inst_rdata_d = bus_rdata;
              inst_ok_d    = 1'b1;
            end
          end
        end else if (flush) begin
          // Requester has gone away; swallow the pending data phase.
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus_data_ok) begin
          cancel_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= DATA;
      ptr_q        <= DATA;
      cancel_q     <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_wr_q     <= 1'b0;
      bus_size_q   <= '0;
      bus_addr_q   <= '0;
      bus_wstrb_q  <= '0;
      bus_wdata_q  <= '0;
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      cancel_q     <= cancel_d;
      bus_req_q    <= bus_req_d;
      bus_wr_q     <= bus_wr_d;
      bus_size_q   <= bus_size_d;
      bus_addr_q   <= bus_addr_d;
      bus_wstrb_q  <= bus_wstrb_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_ok_q    <= inst_ok_d;
      data_ok_q    <= data_ok_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_wr     = bus_wr_q;
  assign bus_size   = bus_size_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wstrb  = bus_wstrb_q;
  assign bus_wdata  = bus_wdata_q;
  assign inst_ok    = inst_ok_q;
  assign data_ok    = data_ok_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: table of single transactions plus
// hand-written flush, reset and contention sequences.
module tb_sram_like_arbiter;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ok;
  logic        bus_req;
  logic        bus_wr;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;
  logic        busy;

  int unsigned total;
  int unsigned bad;

  sram_like_arbiter #(.AW(32), .DW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_rdata  (inst_rdata),
    .inst_ok     (inst_ok),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_addr   (data_addr),
    .data_wstrb  (data_wstrb),
    .data_wdata  (data_wdata),
    .data_rdata  (data_rdata),
    .data_ok     (data_ok),
    .bus_req     (bus_req),
    .bus_wr      (bus_wr),
    .bus_size    (bus_size),
    .bus_addr    (bus_addr),
    .bus_wstrb   (bus_wstrb),
    .bus_wdata   (bus_wdata),
    .bus_addr_ok (bus_addr_ok),
    .bus_data_ok (bus_data_ok),
    .bus_rdata   (bus_rdata),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          own_data;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned alat;
    int unsigned dlat;
    logic        exp_wr;
    logic [1:0]  exp_size;
    logic [3:0]  exp_wstrb;
  } vec_t;

  vec_t vecs[6];

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".bus_req"}, {31'd0, bus_req}, 32'd0);
    chk({tag, ".bus_wr"}, {31'd0, bus_wr}, 32'd0);
    chk({tag, ".bus_size"}, {30'd0, bus_size}, 32'd0);
    chk({tag, ".bus_addr"}, bus_addr, 32'd0);
    chk({tag, ".bus_wstrb"}, {28'd0, bus_wstrb}, 32'd0);
    chk({tag, ".bus_wdata"}, bus_wdata, 32'd0);
    chk({tag, ".inst_ok"}, {31'd0, inst_ok}, 32'd0);
    chk({tag, ".data_ok"}, {31'd0, data_ok}, 32'd0);
    chk({tag, ".inst_rdata"}, inst_rdata, 32'd0);
    chk({tag, ".data_rdata"}, data_rdata, 32'd0);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Issue one transaction and play the bus slave; starts and ends at a
  // negedge with the arbiter idle.
  task automatic run_txn(input vec_t v, input string tag);
    if (v.own_data) begin
      data_req   = 1'b1;
      data_wr    = v.wr;
      data_size  = v.size;
      data_addr  = v.addr;
      data_wstrb = v.wstrb;
      data_wdata = v.wdata;
    end else begin
      inst_req  = 1'b1;
      inst_addr = v.addr;
    end
    step();
    chk({tag, ".bus_req"}, {31'd0, bus_req}, 32'd1);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
    chk({tag, ".bus_addr"}, bus_addr, v.addr);
    chk({tag, ".bus_wr"}, {31'd0, bus_wr}, {31'd0, v.exp_wr});
    chk({tag, ".bus_size"}, {30'd0, bus_size}, {30'd0, v.exp_size});
    chk({tag, ".bus_wstrb"}, {28'd0, bus_wstrb}, {28'd0, v.exp_wstrb});
    if (v.exp_wr) chk({tag, ".bus_wdata"}, bus_wdata, v.wdata);
    for (int unsigned i = 0; i < v.alat; i++) begin
      step();
      chk({tag, ".req_held"}, {31'd0, bus_req}, 32'd1);
      chk({tag, ".addr_held"}, bus_addr, v.addr);
    end
    bus_addr_ok = 1'b1;
    step();
    bus_addr_ok = 1'b0;
    chk({tag, ".req_drop"}, {31'd0, bus_req}, 32'd0);
    chk({tag, ".busy_wait"}, {31'd0, busy}, 32'd1);
    for (int unsigned i = 0; i < v.dlat; i++) begin
      step();
      chk({tag, ".no_early_ok"}, {31'd0, inst_ok | data_ok}, 32'd0);
    end
    bus_data_ok = 1'b1;
    bus_rdata   = v.rdata;
    step();
    bus_data_ok = 1'b0;
    if (v.own_data) begin
      chk({tag, ".data_ok"}, {31'd0, data_ok}, 32'd1);
      chk({tag, ".data_rdata"}, data_rdata, v.rdata);
      chk({tag, ".inst_ok_quiet"}, {31'd0, inst_ok}, 32'd0);
      data_req = 1'b0;
    end else begin
      chk({tag, ".inst_ok"}, {31'd0, inst_ok}, 32'd1);
      chk({tag, ".inst_rdata"}, inst_rdata, v.rdata);
      chk({tag, ".data_ok_quiet"}, {31'd0, data_ok}, 32'd0);
      inst_req = 1'b0;
    end
    step();
    chk({tag, ".ok_single"}, {31'd0, inst_ok | data_ok}, 32'd0);
    chk({tag, ".busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  // From the cycle bus_req is visible: accept address, return data; ends in
  // the ok cycle.
  task automatic serve(input logic [31:0] rd);
    bus_addr_ok = 1'b1;
    step();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata   = rd;
    step();
    bus_data_ok = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  localparam logic [31:0] D_ADDR = 32'h8000_1000;
  localparam logic [31:0] I_ADDR = 32'hBFC0_0100;

  initial begin
    vector_setup: begin
      //          own wr size  addr          wstrb wdata         rdata         al dl ewr esz ewstrb
      vecs[0] = '{1'b1, 1'b0, 2'd2, 32'h8000_0004, 4'hF, 32'h1234_5678, 32'hDEAD_BEEF, 0, 0, 1'b0, 2'd2, 4'h0};
      vecs[1] = '{1'b1, 1'b1, 2'd0, 32'h8000_0003, 4'h8, 32'hAAAA_AAAA, 32'h0000_0000, 1, 2, 1'b1, 2'd0, 4'h8};
      vecs[2] = '{1'b1, 1'b1, 2'd1, 32'h8000_0002, 4'hC, 32'h5555_5555, 32'h0000_0000, 0, 1, 1'b1, 2'd1, 4'hC};
      vecs[3] = '{1'b0, 1'b1, 2'd0, 32'hBFC0_0000, 4'hF, 32'hFFFF_FFFF, 32'h3C08_0001, 2, 0, 1'b0, 2'd2, 4'h0};
      vecs[4] = '{1'b1, 1'b1, 2'd2, 32'h8000_0010, 4'hF, 32'h0102_0304, 32'h0000_0000, 0, 0, 1'b1, 2'd2, 4'hF};
      vecs[5] = '{1'b0, 1'b0, 2'd2, 32'hBFC0_0004, 4'h0, 32'h0000_0000, 32'h8C09_0004, 0, 3, 1'b0, 2'd2, 4'h0};
    end

    total = 0;
    bad   = 0;
    rst = 1'b1; flush = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_addr = '0;
    data_wstrb = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    step();
    step();
    rst = 1'b0;
    chk_idle_zero("reset");

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Flush while the address phase is stalled.
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = D_ADDR;
    step();
    chk("flreq.bus_req", {31'd0, bus_req}, 32'd1);
    step();
    flush = 1'b1; data_req = 1'b0;
    step();
    flush = 1'b0;
    chk("flreq.req_held", {31'd0, bus_req}, 32'd1);
    step();
    chk("flreq.req_held2", {31'd0, bus_req}, 32'd1);
    bus_addr_ok = 1'b1;
    step();
    bus_addr_ok = 1'b0;
    chk("flreq.req_drop", {31'd0, bus_req}, 32'd0);
    chk("flreq.busy_drain", {31'd0, busy}, 32'd1);
    chk("flreq.no_ok1", {31'd0, data_ok | inst_ok}, 32'd0);
    bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
    step();
    bus_data_ok = 1'b0;
    chk("flreq.no_ok2", {31'd0, data_ok | inst_ok}, 32'd0);
    chk("flreq.busy_clear", {31'd0, busy}, 32'd0);
    step();
    chk("flreq.no_ok3", {31'd0, data_ok | inst_ok}, 32'd0);

    // Flush coincident with the data phase.
    data_req = 1'b1; data_addr = D_ADDR;
    step();
    chk("flwait.bus_req", {31'd0, bus_req}, 32'd1);
    bus_addr_ok = 1'b1;
    step();
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1; bus_rdata = 32'h1111_2222; flush = 1'b1; data_req = 1'b0;
    step();
    bus_data_ok = 1'b0; flush = 1'b0;
    chk("flwait.no_ok", {31'd0, data_ok | inst_ok}, 32'd0);
    chk("flwait.idle", {31'd0, busy}, 32'd0);
    run_txn(vecs[0], "flwait.next");

    // Reset during the data phase wait.
    inst_req = 1'b1; inst_addr = I_ADDR;
    step();
    bus_addr_ok = 1'b1;
    step();
    bus_addr_ok = 1'b0;
    chk("rstwait.busy", {31'd0, busy}, 32'd1);
    rst = 1'b1; inst_req = 1'b0;
    step();
    rst = 1'b0;
    chk_idle_zero("rstwait");
    run_txn(vecs[5], "rstwait.fetch");

    // Simultaneous requests: data first, inst granted in data's ok cycle.
    do_reset();
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = D_ADDR;
    inst_req = 1'b1; inst_addr = I_ADDR;
    step();
    chk("cont.first_addr", bus_addr, D_ADDR);
    serve(32'hAAAA_0001);
    chk("cont.data_ok", {31'd0, data_ok}, 32'd1);
    chk("cont.data_rdata", data_rdata, 32'hAAAA_0001);
    data_req = 1'b0;
    step();
    chk("cont.second_req", {31'd0, bus_req}, 32'd1);
    chk("cont.second_addr", bus_addr, I_ADDR);
    serve(32'hBBBB_0002);
    chk("cont.inst_ok", {31'd0, inst_ok}, 32'd1);
    chk("cont.inst_rdata", inst_rdata, 32'hBBBB_0002);
    inst_req = 1'b0;
    step();
    chk("cont.idle", {31'd0, busy}, 32'd0);

    // Repeated conflicts, one grant each round.
    for (int k = 0; k < 4; k++) begin
      logic exp_data;
`ifdef ARB_RR_EN
      exp_data = ((k % 2) == 0);
`else
      exp_data = 1'b1;
`endif
      data_req = 1'b1; inst_req = 1'b1;
      step();
      chk($sformatf("rr%0d.winner_addr", k), bus_addr, exp_data ? D_ADDR : I_ADDR);
      if (exp_data) inst_req = 1'b0; else data_req = 1'b0;
      serve(32'h0000_1000 + k);
      chk($sformatf("rr%0d.ok", k), {30'd0, data_ok, inst_ok}, exp_data ? 32'd2 : 32'd1);
      data_req = 1'b0; inst_req = 1'b0;
      step();
      chk($sformatf("rr%0d.idle", k), {31'd0, busy}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
